// File: rtl/uart_receiver_if.sv
// Serial-side and byte-side signals of the UART receiver.
// The master modport drives the line; the slave modport is the receiver itself.
interface uart_receiver_if;
    logic       data_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    modport master (
        output data_in,
        input  data_out,
        input  data_valid,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  data_in,
        output data_out,
        output data_valid,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop line synchronizer, mid-bit sampling FSM,
// one-cycle data_valid / frame_err pulses and a BREAK hold after a bad stop bit.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic            clk_in,
    input  logic            reset,
    uart_receiver_if.slave  bus
);
    localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    logic             r_sync1;
    logic             r_sync2;
    logic             w_line;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data_out;
    logic             r_data_valid;
    logic             r_frame_err;

    // Line synchronizer; flops reset to the idle (high) level.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.data_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_line = r_sync2;

    // Receive FSM with registered byte and pulse outputs.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_idx        <= 3'd0;
            r_shift      <= 8'h00;
            r_data_out   <= 8'h00;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!w_line) begin
                        r_state <= S_START;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_START: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt <= '0;
                        r_idx <= 3'd0;
                        // A high line at mid start bit is a glitch, not a frame.
                        if (!w_line) begin
                            r_state <= S_DATA;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (r_cnt == FULL_LAST) begin
                        r_cnt          <= '0;
                        r_shift[r_idx] <= w_line;
                        r_idx          <= r_idx + 3'd1;
                        if (r_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (r_cnt == FULL_LAST) begin
                        r_cnt <= '0;
                        if (w_line) begin
                            r_data_out   <= r_shift;
                            r_data_valid <= 1'b1;
                            r_state      <= S_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_BREAK: begin
                    r_cnt <= '0;
                    if (w_line) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_BREAK;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_idx   <= 3'd0;
                end
            endcase
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.data_valid = r_data_valid;
    assign bus.frame_err  = r_frame_err;
    assign bus.busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: bytes sent with a good stop bit are queued
// and matched against data_valid pulses captured by a negedge monitor.
module tb_uart_receiver;
    localparam int CPB = 16;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    int   cyc;
    int   ferr_cnt;
    bit   both_seen;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int         obs_cyc[$];

    uart_receiver_if u_if ();

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk_in (clk),
        .reset  (rst),
        .bus    (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        ferr_cnt  = 0;
        both_seen = 1'b0;
    end

    // Output monitor, sampled half a cycle away from the active edge.
    always @(negedge clk) begin
        if (u_if.data_valid === 1'b1) begin
            obs_q.push_back(u_if.data_out);
            obs_cyc.push_back(cyc);
        end
        if (u_if.frame_err === 1'b1) ferr_cnt = ferr_cnt + 1;
        if (u_if.data_valid === 1'b1 && u_if.frame_err === 1'b1) both_seen = 1'b1;
    end

    task automatic drive_bit(input logic v);
        u_if.data_in = v;
        repeat (CPB) @(negedge clk);
    endtask

    // Called on a negedge; returns on a negedge after the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_v, output int start_c);
        start_c = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_v);
        if (stop_v) exp_q.push_back(b);
    endtask

    task automatic wait_obs(input int n);
        for (int k = 0; k < 400 && obs_q.size() < n; k++) @(negedge clk);
    endtask

    task automatic test_reset;
        u_if.data_in = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_total++; if (u_if.data_out !== 8'h00) $display("FAIL reset_data_out got=%h exp=00", u_if.data_out); else n_pass++;
        n_total++; if (u_if.data_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", u_if.data_valid); else n_pass++;
        n_total++; if (u_if.frame_err !== 1'b0) $display("FAIL reset_ferr got=%b exp=0", u_if.frame_err); else n_pass++;
        n_total++; if (u_if.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", u_if.busy); else n_pass++;
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_low_through_reset;
        logic [7:0] b;
        b = 8'hC3;
        rst = 1'b1;
        u_if.data_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_total++; if (u_if.busy !== 1'b0) $display("FAIL lowrst_busy_c1 got=%b exp=0", u_if.busy); else n_pass++;
        @(negedge clk);
        n_total++; if (u_if.busy !== 1'b0) $display("FAIL lowrst_busy_c2 got=%b exp=0", u_if.busy); else n_pass++;
        @(negedge clk);
        n_total++; if (u_if.busy !== 1'b1) $display("FAIL lowrst_busy_c3 got=%b exp=1", u_if.busy); else n_pass++;
        repeat (CPB - 3) @(negedge clk);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(1'b1);
        exp_q.push_back(b);
        wait_obs(1);
        n_total++; if (obs_q.size() != 1) $display("FAIL lowrst_count got=%0d exp=1", obs_q.size()); else n_pass++;
        if (obs_q.size() > 0 && exp_q.size() > 0) begin
            n_total++;
            if (obs_q[0] !== exp_q[0]) $display("FAIL lowrst_value got=%h exp=%h", obs_q[0], exp_q[0]); else n_pass++;
        end
        obs_q.delete(); obs_cyc.delete(); exp_q.delete();
        repeat (10) @(negedge clk);
    endtask

    task automatic test_single;
        int s;
        int f0;
        f0 = ferr_cnt;
        send_frame(8'hA5, 1'b1, s);
        wait_obs(1);
        n_total++; if (obs_q.size() != 1) $display("FAIL single_count got=%0d exp=1", obs_q.size()); else n_pass++;
        if (obs_q.size() > 0 && exp_q.size() > 0) begin
            n_total++;
            if (obs_q[0] !== exp_q[0]) $display("FAIL single_value got=%h exp=%h", obs_q[0], exp_q[0]); else n_pass++;
            n_total++;
            if ((obs_cyc[0] - s) < 152 || (obs_cyc[0] - s) > 156)
                $display("FAIL single_latency got=%0d exp=152..156", obs_cyc[0] - s);
            else n_pass++;
        end
        repeat (5) @(negedge clk);
        n_total++; if (ferr_cnt != f0) $display("FAIL single_ferr got=%0d exp=0", ferr_cnt - f0); else n_pass++;
        n_total++; if (u_if.busy !== 1'b0) $display("FAIL single_busy_after got=%b exp=0", u_if.busy); else n_pass++;
        obs_q.delete(); obs_cyc.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back;
        int s1;
        int s2;
        send_frame(8'h00, 1'b1, s1);
        send_frame(8'hFF, 1'b1, s2);
        u_if.data_in = 1'b1;
        wait_obs(2);
        n_total++; if (obs_q.size() != 2) $display("FAIL b2b_count got=%0d exp=2", obs_q.size()); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            if (obs_q.size() > i && exp_q.size() > i) begin
                n_total++;
                if (obs_q[i] !== exp_q[i]) $display("FAIL b2b_value%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); else n_pass++;
            end
        end
        if (obs_cyc.size() == 2) begin
            n_total++;
            if (obs_cyc[1] - obs_cyc[0] != 160) $display("FAIL b2b_spacing got=%0d exp=160", obs_cyc[1] - obs_cyc[0]); else n_pass++;
        end
        obs_q.delete(); obs_cyc.delete(); exp_q.delete();
        repeat (10) @(negedge clk);
    endtask

    task automatic test_glitch;
        u_if.data_in = 1'b0;
        repeat (4) @(negedge clk);
        u_if.data_in = 1'b1;
        repeat (10) @(negedge clk);
        n_total++; if (u_if.busy !== 1'b0) $display("FAIL glitch_busy got=%b exp=0", u_if.busy); else n_pass++;
        repeat (20) @(negedge clk);
        n_total++; if (obs_q.size() != 0) $display("FAIL glitch_pulses got=%0d exp=0", obs_q.size()); else n_pass++;
        n_total++; if (u_if.data_out !== 8'hFF) $display("FAIL glitch_data_out got=%h exp=ff", u_if.data_out); else n_pass++;
    endtask

    task automatic test_frame_err;
        int s;
        int f0;
        logic busy_low_seen;
        f0 = ferr_cnt;
        busy_low_seen = 1'b0;
        send_frame(8'h3C, 1'b0, s);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (u_if.busy !== 1'b1) busy_low_seen = 1'b1;
        end
        n_total++; if (busy_low_seen) $display("FAIL ferr_busy_hold got=0 exp=1"); else n_pass++;
        n_total++; if (ferr_cnt - f0 != 1) $display("FAIL ferr_pulses got=%0d exp=1", ferr_cnt - f0); else n_pass++;
        n_total++; if (obs_q.size() != 0) $display("FAIL ferr_valid got=%0d exp=0", obs_q.size()); else n_pass++;
        n_total++; if (u_if.data_out !== 8'hFF) $display("FAIL ferr_data_out got=%h exp=ff", u_if.data_out); else n_pass++;
        u_if.data_in = 1'b1;
        repeat (5) @(negedge clk);
        n_total++; if (u_if.busy !== 1'b0) $display("FAIL ferr_busy_release got=%b exp=0", u_if.busy); else n_pass++;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_midframe;
        logic [7:0] b;
        int s;
        b = 8'h55;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        u_if.data_in = b[4];
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        u_if.data_in = 1'b1;
        repeat (3) @(negedge clk);
        n_total++; if (u_if.busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", u_if.busy); else n_pass++;
        n_total++; if (u_if.data_out !== 8'h00) $display("FAIL midrst_data_out got=%h exp=00", u_if.data_out); else n_pass++;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        n_total++; if (obs_q.size() != 0) $display("FAIL midrst_no_pulse got=%0d exp=0", obs_q.size()); else n_pass++;
        send_frame(8'h81, 1'b1, s);
        wait_obs(1);
        n_total++; if (obs_q.size() != 1) $display("FAIL midrst_count got=%0d exp=1", obs_q.size()); else n_pass++;
        if (obs_q.size() > 0 && exp_q.size() > 0) begin
            n_total++;
            if (obs_q[0] !== exp_q[0]) $display("FAIL midrst_value got=%h exp=%h", obs_q[0], exp_q[0]); else n_pass++;
        end
        obs_q.delete(); obs_cyc.delete(); exp_q.delete();
        repeat (5) @(negedge clk);
    endtask

    task automatic test_final;
        n_total++; if (both_seen) $display("FAIL exclusive_pulses got=1 exp=0"); else n_pass++;
        n_total++; if (obs_q.size() != 0) $display("FAIL leftover_pulses got=%0d exp=0", obs_q.size()); else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst = 1'b1;
        u_if.data_in = 1'b1;
        @(negedge clk);
        test_reset;
        test_low_through_reset;
        test_single;
        test_back_to_back;
        test_glitch;
        test_frame_err;
        test_reset_midframe;
        test_final;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter: CLKS_PER_BIT, 16, clk_in cycles per serial bit; even, >= 4.
REQ-002 clk_in  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 data_in  input  1  asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-005 data_out  output  8  last correctly framed byte received.
REQ-006 data_valid  output  1  one-cycle pulse: data_out updated this cycle.
REQ-007 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-008 busy  output  1  high whenever state is not IDLE.

Function
REQ-009 data_in SHALL pass a two-flop synchronizer before any use; both flops set to 1 by reset.
REQ-010 States SHALL be IDLE, START, DATA, STOP and BREAK, encoded in a 3-bit register.
REQ-011 Bit-timing counter width SHALL be clog2(CLKS_PER_BIT); bit index counter 3 bits.
REQ-012 IDLE: synchronized line low -> START with counter cleared; otherwise stay in IDLE.
REQ-013 START: counter runs to CLKS_PER_BIT/2-1 (mid start bit), then samples the line.
  - Line low -> DATA, counter and bit index cleared.
  - Line high -> IDLE, glitch rejected, no pulse.
REQ-014 DATA: sample the line every CLKS_PER_BIT cycles (bit centres) and shift it into bit[index], LSB first.
  - After the 8th sample (index 7) -> STOP, counter cleared.
REQ-015 STOP: sample after CLKS_PER_BIT cycles.
  - High -> data_out <= shift register, data_valid = 1 for one cycle, -> IDLE.
  - Low -> frame_err = 1 for one cycle, data_out unchanged, -> BREAK.
REQ-016 BREAK: stay until synchronized line high, then -> IDLE; no pulses while in BREAK.
REQ-017 data_out SHALL hold its value between data_valid pulses.
REQ-018 data_valid and frame_err SHALL never be high in the same cycle.
REQ-019 Timing: data_valid SHALL assert within [9.5*CLKS_PER_BIT, 9.5*CLKS_PER_BIT+4] clk_in cycles of the start-bit falling edge.
REQ-020 Back-to-back frames: a start edge arriving in the first cycle after returning to IDLE SHALL be accepted, with no lost frame.
REQ-021 Unreachable state encodings SHALL transition to IDLE on the next clock.

Reset
REQ-022 Reset SHALL force the following values:
  - State IDLE; counters 0; shift register 0x00.
  - data_out = 0x00; data_valid = 0; frame_err = 0; busy = 0.
  - Synchronizer flops = 1.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no pulse; after release the line must be seen high-to-low afresh before a new frame starts.
REQ-024 A line held low through reset release SHALL start a frame from IDLE only after the two-cycle synchronizer latency.

Verification (CLKS_PER_BIT = 16)
REQ-025 Send frame 0xA5 with a valid stop bit -> one data_valid pulse, data_out = 0xA5, frame_err never high, busy low afterwards.
REQ-026 Send 0x00 then 0xFF back-to-back with no idle gap -> two data_valid pulses, values 0x00 then 0xFF, spaced 160 cycles apart.
REQ-027 Low glitch of 4 cycles on an idle line -> return to IDLE within 10 cycles, no pulses, data_out unchanged.
REQ-028 Send 0x3C with stop bit forced low, then hold the line low for 40 cycles -> one frame_err pulse, data_out keeps its previous value, busy high until the line returns high.
REQ-029 Assert reset at data bit 4 of a 0x55 frame, then release and send 0x81 -> no pulse for 0x55, data_valid with data_out = 0x81.
REQ-030 Start-bit edge to data_valid -> latency within the REQ-019 window (152 to 156 cycles).
